// File: rtl/pwm_duty_ramp.sv
// Slews the PWM duty toward a requested target by STEP per step tick.
// Duty only changes when the period counter wraps, so the PWM never sees a mid-period change.
module pwm_duty_ramp #(
    parameter int WIDTH     = 11,
    parameter int STEP      = 64,
    parameter int PPS       = 1,
    parameter int INIT_DUTY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tgt_duty,
    input  logic             tgt_vld,
    output logic             tgt_rdy,
    input  logic             abort,
    output logic [WIDTH-1:0] duty,
    output logic             busy,
    output logic             done
);

    localparam int                SCW       = (PPS > 1) ? $clog2(PPS) : 1;
    localparam logic [SCW-1:0]    STEP_LAST = SCW'(PPS - 1);
    localparam logic [WIDTH-1:0]  STEP_D    = WIDTH'(STEP);
    localparam logic [WIDTH:0]    STEP_X    = (WIDTH+1)'(STEP);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prd_cnt;
    logic [SCW-1:0]   r_step_cnt;
    logic [WIDTH-1:0] r_tgt_q;
    logic [WIDTH-1:0] r_duty;
    logic             r_busy;
    logic             r_done;

    logic             w_prd_end;
    logic             w_step_tick;
    logic             w_accept;
    logic             w_step;
    logic             w_finish;
    logic             w_up;
    logic [WIDTH:0]   w_mag;
    logic             w_close;

    assign w_prd_end   = &r_prd_cnt;
    assign w_step_tick = w_prd_end && (r_step_cnt == STEP_LAST);
    assign tgt_rdy     = (r_state == S_IDLE);
    assign duty        = r_duty;
    assign busy        = r_busy;
    assign done        = r_done;

    // Distance to target in WIDTH+1 bits so the clamp decision can never wrap.
    assign w_up    = (r_tgt_q > r_duty);
    assign w_mag   = w_up ? ({1'b0, r_tgt_q} - {1'b0, r_duty})
                          : ({1'b0, r_duty} - {1'b0, r_tgt_q});
    assign w_close = (w_mag <= STEP_X);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tgt_vld) begin
                    w_accept = 1'b1;
                    if (tgt_duty != r_duty) begin
                        w_state_nxt = S_RAMP;
                    end
                end
            end
            S_RAMP: begin
                // Abort wins over a coincident step tick and never produces done.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_step_tick) begin
                    w_step = 1'b1;
                    if (w_close) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_prd_cnt  <= '0;
            r_step_cnt <= '0;
            r_duty     <= WIDTH'(INIT_DUTY);
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prd_cnt <= r_prd_cnt + WIDTH'(1);
            if (w_accept) begin
                r_step_cnt <= '0;
            end else if (w_prd_end) begin
                r_step_cnt <= (r_step_cnt == STEP_LAST) ? '0 : r_step_cnt + SCW'(1);
            end
            if (w_step) begin
                if (w_finish) begin
                    r_duty <= r_tgt_q;
                end else if (w_up) begin
                    r_duty <= r_duty + STEP_D;
                end else begin
                    r_duty <= r_duty - STEP_D;
                end
            end
            r_busy <= (w_state_nxt == S_RAMP);
            r_done <= (w_accept && (tgt_duty == r_duty)) || w_finish;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tgt_q <= tgt_duty;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Randomised and directed bench for pwm_duty_ramp against a per-edge behavioural model.
// Uses a reduced configuration (8-bit duty, STEP 16, two periods per step) to keep runs short.
module tb_pwm_duty_ramp;

    localparam int W      = 8;
    localparam int STP    = 16;
    localparam int P      = 2;
    localparam int PERIOD = 1 << W;
    localparam int MAXD   = PERIOD - 1;
    localparam int BOUND  = 20000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] tgt_duty;
    logic         tgt_vld;
    logic         tgt_rdy;
    logic         abort;
    logic [W-1:0] duty;
    logic         busy;
    logic         done;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: applied duty, accepted target, ramp flag, clocks since reset,
    // period ends seen since the last accept.
    int m_duty, m_tgt, m_t, m_pcnt;
    bit m_ramp, m_done, m_acc;

    pwm_duty_ramp #(.WIDTH(W), .STEP(STP), .PPS(P), .INIT_DUTY(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgt_duty (tgt_duty),
        .tgt_vld  (tgt_vld),
        .tgt_rdy  (tgt_rdy),
        .abort    (abort),
        .duty     (duty),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        bit prd_end;
        int d;
        @(posedge clk);
        prd_end = ((m_t % PERIOD) == PERIOD - 1);
        m_t++;
        m_done = 1'b0;
        m_acc  = 1'b0;
        if (!m_ramp) begin
            if (tgt_vld) begin
                m_acc  = 1'b1;
                m_tgt  = int'(tgt_duty);
                m_pcnt = 0;
                if (m_tgt == m_duty) m_done = 1'b1;
                else                 m_ramp = 1'b1;
            end
        end else if (abort) begin
            m_ramp = 1'b0;
        end else if (prd_end) begin
            m_pcnt++;
            if (m_pcnt == P) begin
                m_pcnt = 0;
                d = m_tgt - m_duty;
                if (d <= STP && d >= -STP) begin
                    m_duty = m_tgt;
                    m_ramp = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_duty = (d > 0) ? m_duty + STP : m_duty - STP;
                end
            end
        end
        #1;
        chk("duty", 32'(duty), 32'(m_duty));
        chk("busy", 32'(busy), 32'(m_ramp));
        chk("done", 32'(done), 32'(m_done));
        chk("tgt_rdy", 32'(tgt_rdy), 32'(!m_ramp));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tgt_vld  = 1'b0;
        abort    = 1'b0;
        #1;
        m_duty = 0; m_tgt = 0; m_t = 0; m_pcnt = 0;
        m_ramp = 1'b0; m_done = 1'b0; m_acc = 1'b0;
        chk("rst_duty", 32'(duty), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdy", 32'(tgt_rdy), 32'h1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic request(input int tgt);
        tgt_duty = W'(tgt);
        tgt_vld  = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            cycle();
            if (m_acc) break;
        end
        tgt_vld = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < BOUND; i++) begin
            if (!m_ramp) break;
            cycle();
        end
        chk("idle_busy", 32'(busy), 32'h0);
    endtask

    // Stop just before the edge that would apply the next step.
    task automatic run_to_step_edge();
        for (int i = 0; i < BOUND; i++) begin
            if (((m_t % PERIOD) == PERIOD - 1) && (m_pcnt == P - 1)) break;
            cycle();
        end
    endtask

    initial begin
        int tgt;
        tgt_duty = '0;
        tgt_vld  = 1'b0;
        abort    = 1'b0;

        // Reset values and ramp up 0x00 -> 0x80 in eight steps.
        do_reset();
        repeat (5) cycle();
        request(8'h80);
        wait_idle();
        chk("t2_duty", 32'(duty), 32'h80);

        // Clamped single step down, then climb and clamp at the top of range.
        request(8'h78);
        wait_idle();
        chk("t3_down_clamp", 32'(duty), 32'h78);
        request(8'hF0);
        wait_idle();
        request(8'hFF);
        wait_idle();
        chk("t3_top_clamp", 32'(duty), 32'hFF);

        // Equal target: immediate done, no ramp.
        request(8'hFF);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        cycle();
        chk("t4_duty", 32'(duty), 32'hFF);

        // Abort on the same edge as the fourth step tick.
        do_reset();
        request(8'hC0);
        for (int i = 0; i < BOUND; i++) begin
            if (m_duty == 'h30) break;
            cycle();
        end
        run_to_step_edge();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("t5_frozen", 32'(duty), 32'h30);
        chk("t5_rdy", 32'(tgt_rdy), 32'h1);
        repeat (3) cycle();
        // Abort while idle does not block acceptance.
        abort = 1'b1;
        request(8'h20);
        abort = 1'b0;
        chk("t5_idle_abort_busy", 32'(busy), 32'h1);
        wait_idle();
        chk("t5_new_tgt", 32'(duty), 32'h20);

        // Target held during a ramp is taken only once idle; then reset mid-ramp.
        request(8'h60);
        request(8'h10);
        chk("t6_late_accept_duty", 32'(duty), 32'h60);
        wait_idle();
        chk("t6_second_tgt", 32'(duty), 32'h10);
        request(8'h00);
        wait_idle();
        chk("t6_bottom", 32'(duty), 32'h00);
        request(8'h70);
        repeat (700) cycle();
        do_reset();

        // Random targets near the current duty, random gaps and rare aborts.
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 5)) cycle();
            tgt = m_duty + (int'($urandom_range(0, 6)) - 3) * STP + int'($urandom_range(0, 16)) - 8;
            if (tgt < 0)    tgt = 0;
            if (tgt > MAXD) tgt = MAXD;
            request(tgt);
            for (int i = 0; i < BOUND; i++) begin
                if (!m_ramp) break;
                abort = ($urandom_range(0, 299) == 0);
                cycle();
            end
            abort = 1'b0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
